sha256_padder: RTL and testbench

Upstream stage of the SHA-256 message-schedule datapath: accepts a message one byte per cycle and emits complete, padded 512-bit blocks on the `blk` bus that the schedule loads with `ld_mreg`. It appends the `0x80` marker, zero fill and the 64-bit big-endian bit length per FIPS 180-4, generating a second block when the length field does not fit. A valid/ready handshake sits on both sides, and the stage stalls byte input while a block is waiting downstream.

---
 rtl/sha256_padder.sv | 175 +++++++++++++++++
 tb/tb_sha256_padder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// sha256_padder: byte-serial SHA-256 message padder feeding 512-bit blocks
// to the message schedule. Appends the 0x80 marker, zero fill and the
// 64-bit big-endian bit length, emitting a second block when needed.
// Optional feature macro: SHA256_PADDER_EMPTY_EN adds the msg_empty input
// for zero-length messages.
module sha256_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_vld,
  input  logic         byte_last,
  output logic         byte_rdy,
`ifdef SHA256_PADDER_EMPTY_EN
  input  logic         msg_empty,
`endif
  output logic [511:0] blk,
  output logic         blk_vld,
  output logic         blk_last,
  input  logic         blk_rdy
);

  localparam int unsigned BLK_W   = 512;
  localparam int unsigned NBYTES  = 64;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned LFLD_W  = 64;
  localparam int unsigned LEN_POS = 56;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_PAD   = 2'd1,
    S_EMIT  = 2'd2,
    S_EXTRA = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   buf_q, buf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   bitlen_q, bitlen_d;
  logic               need_x_q, need_x_d;
  logic               pend_q, pend_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [LFLD_W-1:0]  len_field;
  logic               byte_xfer;
  logic               last_slot;
  logic               empty_go;

  // Byte-side ready is a pure state decode, forced low while in reset
  assign byte_rdy  = (state_q == S_FILL) && !rst;
  assign byte_xfer = byte_vld && byte_rdy;
  assign last_slot = (idx_q == IDX_W'(NBYTES - 1));
  assign len_field = LFLD_W'(bitlen_q);

`ifdef SHA256_PADDER_EMPTY_EN
  // Zero-length message request; a concurrent byte takes priority
  assign empty_go = (state_q == S_FILL) && (idx_q == '0) && !byte_vld && msg_empty;
`else
  assign empty_go = 1'b0;
`endif

  assign blk      = buf_q;
  assign blk_vld  = vld_q;
  assign blk_last = last_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        if (byte_xfer) begin
          if (last_slot)      state_d = S_EMIT;
          else if (byte_last) state_d = S_PAD;
        end else if (empty_go) begin
          state_d = S_PAD;
        end
      end
      S_PAD:   state_d = S_EMIT;
      S_EMIT:  if (blk_rdy) state_d = need_x_q ? S_EXTRA : S_FILL;
      S_EXTRA: state_d = S_EMIT;
      default: state_d = S_FILL;
    endcase
  end

  // Block buffer, counters and output flags for the next cycle
  always_comb begin
    buf_d    = buf_q;
    idx_d    = idx_q;
    bitlen_d = bitlen_q;
    need_x_d = need_x_q;
    pend_d   = pend_q;
    last_d   = last_q;
    unique case (state_q)
      S_FILL: begin
        if (byte_xfer) begin
          for (int j = 0; j < int'(NBYTES); j++) begin
            if (IDX_W'(j) == idx_q) buf_d[8*(63-j) +: 8] = byte_in;
          end
          idx_d    = idx_q + IDX_W'(1);
          bitlen_d = bitlen_q + LEN_W'(8);
          if (last_slot) begin
            last_d = 1'b0;
            if (byte_last) begin
              // Block is full of data: marker and length both go to the next block
              need_x_d = 1'b1;
              pend_d   = 1'b1;
            end
          end
        end
      end
      S_PAD: begin
        for (int j = 0; j < int'(NBYTES); j++) begin
          if (j == int'(idx_q))     buf_d[8*(63-j) +: 8] = 8'h80;
          else if (j > int'(idx_q)) buf_d[8*(63-j) +: 8] = 8'h00;
        end
        if (idx_q < IDX_W'(LEN_POS)) begin
          buf_d[LFLD_W-1:0] = len_field;
          last_d            = 1'b1;
        end else begin
          // Length does not fit behind the marker
          need_x_d = 1'b1;
          pend_d   = 1'b0;
          last_d   = 1'b0;
        end
      end
      S_EMIT: begin
        if (blk_rdy && !need_x_q) begin
          idx_d = '0;
          if (last_q) bitlen_d = '0;
        end
      end
      S_EXTRA: begin
        buf_d = '0;
        if (pend_q) buf_d[BLK_W-1 -: 8] = 8'h80;
        buf_d[LFLD_W-1:0] = len_field;
        last_d   = 1'b1;
        need_x_d = 1'b0;
        pend_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // blk_vld is registered from the upcoming state
  assign vld_d = (state_d == S_EMIT);

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '0;
      idx_q    <= '0;
      bitlen_q <= '0;
      need_x_q <= 1'b0;
      pend_q   <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      bitlen_q <= bitlen_d;
      need_x_q <= need_x_d;
      pend_q   <= pend_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed self-checking bench for sha256_padder.
// Build with SHA256_PADDER_EMPTY_EN defined to also cover msg_empty.
`timescale 1ns/1ps
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   byte_in = 8'h00;
  logic         byte_vld = 1'b0;
  logic         byte_last = 1'b0;
  logic         byte_rdy;
  logic [511:0] blk;
  logic         blk_vld;
  logic         blk_last;
  logic         blk_rdy = 1'b0;
`ifdef SHA256_PADDER_EMPTY_EN
  logic         msg_empty = 1'b0;
`endif

  int           n_pass = 0;
  int           n_total = 0;
  logic [7:0]   mbuf [0:127];

  logic         mon_en = 1'b0;
  int           mon_cnt = 0;
  logic [511:0] mon_blk [0:3];
  logic         mon_last [0:3];

  always #5 clk = ~clk;

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_vld  (byte_vld),
    .byte_last (byte_last),
    .byte_rdy  (byte_rdy),
`ifdef SHA256_PADDER_EMPTY_EN
    .msg_empty (msg_empty),
`endif
    .blk       (blk),
    .blk_vld   (blk_vld),
    .blk_last  (blk_last),
    .blk_rdy   (blk_rdy)
  );

  // Block monitor, only used while blk_rdy is held high
  always @(negedge clk) begin
    if (mon_en && blk_vld && blk_rdy && mon_cnt < 4) begin
      mon_blk[mon_cnt]  <= blk;
      mon_last[mon_cnt] <= blk_last;
      mon_cnt           <= mon_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Send mbuf[0..n-1], waiting on byte_rdy; returns number of stall cycles
  task automatic send_seq(input int n, input logic last_en, output int waits);
    int t;
    waits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      byte_vld  = 1'b1;
      byte_in   = mbuf[i];
      byte_last = last_en && (i == n - 1);
      t = 0;
      while (byte_rdy !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      waits += t;
      if (t >= 200) begin
        n_total++;
        $display("FAIL send_timeout: byte %0d byte_rdy=%b want 1", i, byte_rdy);
      end
    end
    @(negedge clk);
    byte_vld  = 1'b0;
    byte_last = 1'b0;
  endtask

  // Wait for a block, capture it, and hand it over with a one-cycle blk_rdy
  task automatic get_block(output logic [511:0] b, output logic l, output logic ok);
    int t;
    t = 0;
    while (blk_vld !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = (blk_vld === 1'b1);
    b  = blk;
    l  = blk_last;
    blk_rdy = 1'b1;
    @(negedge clk);
    blk_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (byte_rdy !== 1'b0) $display("FAIL rst_byte_rdy: got %b want 0", byte_rdy); else n_pass++;
    n_total++; if (blk_vld !== 1'b0) $display("FAIL rst_blk_vld: got %b want 0", blk_vld); else n_pass++;
    n_total++; if (blk_last !== 1'b0) $display("FAIL rst_blk_last: got %b want 0", blk_last); else n_pass++;
    n_total++; if (blk !== 512'd0) $display("FAIL rst_blk: got %h want 0", blk); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (byte_rdy !== 1'b1) $display("FAIL rst_release_rdy: got %b want 1", byte_rdy); else n_pass++;
  endtask

  // "abc": one final block, two cycles after the last byte
  task automatic run_abc(input string tag);
    logic [511:0] exp, b;
    logic l, ok;
    int w;
    exp = '0;
    exp[511:480] = 32'h61626380;
    exp[31:0]    = 32'h00000018;
    mbuf[0] = 8'h61; mbuf[1] = 8'h62; mbuf[2] = 8'h63;
    send_seq(3, 1'b1, w);
    n_total++; if (blk_vld !== 1'b0) $display("FAIL %s_lat1: blk_vld=%b want 0", tag, blk_vld); else n_pass++;
    @(negedge clk);
    n_total++; if (blk_vld !== 1'b1) $display("FAIL %s_lat2: blk_vld=%b want 1", tag, blk_vld); else n_pass++;
    get_block(b, l, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL %s_wait: blk_vld timeout got %b want 1", tag, ok); else n_pass++;
    n_total++; if (b !== exp) $display("FAIL %s_blk: got %h want %h", tag, b, exp); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL %s_last: got %b want 1", tag, l); else n_pass++;
    n_total++; if (byte_rdy !== 1'b1) $display("FAIL %s_refill: byte_rdy=%b want 1", tag, byte_rdy); else n_pass++;
  endtask

  task automatic test_abc();
    run_abc("abc");
  endtask

  task automatic test_abcd0123();
    logic [511:0] exp, b;
    logic [63:0] msg;
    logic l, ok;
    int w;
    msg = 64'h6162636430313233;
    for (int i = 0; i < 8; i++) mbuf[i] = msg[63-8*i -: 8];
    exp = '0;
    exp[511:440] = 72'h616263643031323380;
    exp[31:0]    = 32'h00000040;
    send_seq(8, 1'b1, w);
    get_block(b, l, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL a8_wait: got %b want 1", ok); else n_pass++;
    n_total++; if (b !== exp) $display("FAIL a8_blk: got %h want %h", b, exp); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL a8_last: got %b want 1", l); else n_pass++;
  endtask

  // 56 bytes: marker fits, length does not
  task automatic test_two_block_56();
    logic [511:0] exp1, exp2, b;
    logic l, ok;
    int w;
    for (int i = 0; i < 56; i++) mbuf[i] = 8'hAA;
    exp1 = '0;
    for (int j = 0; j < 56; j++) exp1[511-8*j -: 8] = 8'hAA;
    exp1[63:56] = 8'h80;
    exp2 = '0;
    exp2[31:0] = 32'h000001C0;
    send_seq(56, 1'b1, w);
    get_block(b, l, ok);
    n_total++; if (b !== exp1) $display("FAIL b56_blk1: got %h want %h", b, exp1); else n_pass++;
    n_total++; if (l !== 1'b0) $display("FAIL b56_last1: got %b want 0", l); else n_pass++;
    n_total++; if (blk_vld !== 1'b0) $display("FAIL b56_gap: blk_vld=%b want 0", blk_vld); else n_pass++;
    @(negedge clk);
    n_total++; if (blk_vld !== 1'b1) $display("FAIL b56_extra_vld: blk_vld=%b want 1", blk_vld); else n_pass++;
    get_block(b, l, ok);
    n_total++; if (b !== exp2) $display("FAIL b56_blk2: got %h want %h", b, exp2); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL b56_last2: got %b want 1", l); else n_pass++;
  endtask

  // 64 bytes: marker and length both in the extra block
  task automatic test_two_block_64();
    logic [511:0] exp1, exp2, b;
    logic l, ok;
    int w;
    for (int i = 0; i < 64; i++) mbuf[i] = 8'h11;
    exp1 = {64{8'h11}};
    exp2 = '0;
    exp2[511:480] = 32'h80000000;
    exp2[31:0]    = 32'h00000200;
    send_seq(64, 1'b1, w);
    n_total++; if (blk_vld !== 1'b1) $display("FAIL b64_full_lat: blk_vld=%b want 1", blk_vld); else n_pass++;
    get_block(b, l, ok);
    n_total++; if (b !== exp1) $display("FAIL b64_blk1: got %h want %h", b, exp1); else n_pass++;
    n_total++; if (l !== 1'b0) $display("FAIL b64_last1: got %b want 0", l); else n_pass++;
    get_block(b, l, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL b64_wait2: got %b want 1", ok); else n_pass++;
    n_total++; if (b !== exp2) $display("FAIL b64_blk2: got %h want %h", b, exp2); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL b64_last2: got %b want 1", l); else n_pass++;
  endtask

  // Hold off the consumer: block must stay put and bytes must not be taken
  task automatic test_backpressure();
    logic [511:0] b0, b;
    logic l, ok;
    int w, t;
    mbuf[0] = 8'h61; mbuf[1] = 8'h62; mbuf[2] = 8'h63;
    send_seq(3, 1'b1, w);
    t = 0;
    while (blk_vld !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    b0 = blk;
    n_total++; if (b0[511:480] !== 32'h61626380) $display("FAIL bp_word0: got %h want 61626380", b0[511:480]); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      byte_vld  = 1'b1;
      byte_in   = 8'hEE;
      byte_last = 1'b1;
      @(negedge clk);
      n_total++; if (blk !== b0) $display("FAIL bp_stable%0d: got %h want %h", c, blk, b0); else n_pass++;
      n_total++; if (byte_rdy !== 1'b0) $display("FAIL bp_rdy%0d: got %b want 0", c, byte_rdy); else n_pass++;
      n_total++; if (blk_vld !== 1'b1) $display("FAIL bp_vld%0d: got %b want 1", c, blk_vld); else n_pass++;
    end
    byte_vld  = 1'b0;
    byte_last = 1'b0;
    get_block(b, l, ok);
    run_abc("bp_after");
  endtask

  // Reset mid-message and mid-EMIT, then a clean "abc"
  task automatic test_reset_mid();
    int w;
    for (int i = 0; i < 10; i++) mbuf[i] = 8'h55;
    send_seq(10, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (byte_rdy !== 1'b0) $display("FAIL rmid_rdy: got %b want 0", byte_rdy); else n_pass++;
    n_total++; if (blk_vld !== 1'b0) $display("FAIL rmid_vld: got %b want 0", blk_vld); else n_pass++;
    rst = 1'b0;
    run_abc("rmid_msg");
    for (int i = 0; i < 64; i++) mbuf[i] = 8'h33;
    send_seq(64, 1'b0, w);
    n_total++; if (blk_vld !== 1'b1) $display("FAIL remit_pre: blk_vld=%b want 1", blk_vld); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (blk_vld !== 1'b0) $display("FAIL remit_vld: got %b want 0", blk_vld); else n_pass++;
    n_total++; if (blk !== 512'd0) $display("FAIL remit_blk: got %h want 0", blk); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    run_abc("remit_msg");
  endtask

  // 128-byte message with blk_rdy held high: single-cycle EMIT between data blocks
  task automatic test_back_to_back();
    logic [511:0] exp0, exp1, exp2;
    int w, t;
    for (int i = 0; i < 128; i++) mbuf[i] = 8'(i);
    exp0 = '0; exp1 = '0; exp2 = '0;
    for (int j = 0; j < 64; j++) begin
      exp0[511-8*j -: 8] = 8'(j);
      exp1[511-8*j -: 8] = 8'(j + 64);
    end
    exp2[511:504] = 8'h80;
    exp2[31:0]    = 32'h00000400;
    blk_rdy = 1'b1;
    mon_en  = 1'b1;
    send_seq(128, 1'b1, w);
    n_total++; if (w !== 1) $display("FAIL b2b_stall: got %0d want 1", w); else n_pass++;
    t = 0;
    while (mon_cnt < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    blk_rdy = 1'b0;
    mon_en  = 1'b0;
    n_total++; if (mon_cnt !== 3) $display("FAIL b2b_count: got %0d want 3", mon_cnt); else n_pass++;
    n_total++; if (mon_blk[0] !== exp0) $display("FAIL b2b_blk0: got %h want %h", mon_blk[0], exp0); else n_pass++;
    n_total++; if (mon_last[0] !== 1'b0) $display("FAIL b2b_last0: got %b want 0", mon_last[0]); else n_pass++;
    n_total++; if (mon_blk[1] !== exp1) $display("FAIL b2b_blk1: got %h want %h", mon_blk[1], exp1); else n_pass++;
    n_total++; if (mon_last[1] !== 1'b0) $display("FAIL b2b_last1: got %b want 0", mon_last[1]); else n_pass++;
    n_total++; if (mon_blk[2] !== exp2) $display("FAIL b2b_blk2: got %h want %h", mon_blk[2], exp2); else n_pass++;
    n_total++; if (mon_last[2] !== 1'b1) $display("FAIL b2b_last2: got %b want 1", mon_last[2]); else n_pass++;
  endtask

`ifdef SHA256_PADDER_EMPTY_EN
  task automatic test_empty();
    logic [511:0] exp, b;
    logic l, ok;
    exp = '0;
    exp[511:504] = 8'h80;
    @(negedge clk);
    msg_empty = 1'b1;
    @(negedge clk);
    msg_empty = 1'b0;
    get_block(b, l, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL empty_wait: got %b want 1", ok); else n_pass++;
    n_total++; if (b !== exp) $display("FAIL empty_blk: got %h want %h", b, exp); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL empty_last: got %b want 1", l); else n_pass++;
    run_abc("empty_after");
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_abcd0123();
    test_two_block_56();
    test_two_block_64();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SHA256_PADDER_EMPTY_EN
    test_empty();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
